// File: rtl/l1_cache_param_if.sv
// rtl/l1_cache_param_if.sv - request, eviction and back-invalidation bus of the parametrised L1
interface l1_cache_param_if;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_write;
  logic        req_ready;
  logic        resp_valid;
  logic        resp_hit;
  logic        evict_valid;
  logic [31:0] evict_addr;
  logic        evict_dirty;
  logic        bi_valid;
  logic [31:0] bi_addr;
  logic        bi_done;
  logic        bi_found;

  modport slave (
    input  req_valid, req_addr, req_write, bi_valid, bi_addr,
    output req_ready, resp_valid, resp_hit, evict_valid, evict_addr, evict_dirty,
           bi_done, bi_found
  );

  modport master (
    output req_valid, req_addr, req_write, bi_valid, bi_addr,
    input  req_ready, resp_valid, resp_hit, evict_valid, evict_addr, evict_dirty,
           bi_done, bi_found
  );
endinterface

// File: rtl/l1_cache_param.sv
// rtl/l1_cache_param.sv - tag-only set-associative L1 with LRU/FIFO ranks, dirty write-back and L2 back-invalidation
module l1_cache_param #(
  parameter int WAYS        = 4,
  parameter int BLOCK_BYTES = 16,
  parameter int CACHE_BYTES = 16384,
  parameter int CNT_W       = 20,
  parameter int POLICY      = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  l1_cache_param_if.slave  bus,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count,
  output logic [CNT_W-1:0] wb_count
);
  localparam int OFF_W = $clog2(BLOCK_BYTES);
  localparam int SETS  = CACHE_BYTES / (BLOCK_BYTES * WAYS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 32 - IDX_W - OFF_W;
  localparam int BLK_W = 32 - OFF_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_UPDATE, S_BINV} state_t;

  state_t state_q, state_d;

  logic             valid_q [SETS][WAYS];
  logic             dirty_q [SETS][WAYS];
  logic [TAG_W-1:0] tag_q   [SETS][WAYS];
  logic [WAY_W-1:0] rank_q  [SETS][WAYS];

  logic             live_q;
  logic [BLK_W-1:0] blk_q;
  logic             write_q;

  logic             resp_valid_q, resp_hit_q;
  logic             evict_valid_q, evict_dirty_q;
  logic [31:0]      evict_addr_q;
  logic             bi_done_q, bi_found_q;

  logic             req_ready, accept, start_bi;
  logic [BLK_W-1:0] lk_blk;
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit, inv_any;
  logic [WAY_W-1:0] hit_way, inv_way, old_way, tgt_way, tgt_rank;
  logic             unused_ok;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  assign req_ready = live_q && (state_q == S_IDLE) && !bus.bi_valid;
  assign accept    = req_ready && bus.req_valid;
  assign start_bi  = (state_q == S_IDLE) && bus.bi_valid;
  assign unused_ok = ^{bus.req_addr[OFF_W-1:0], bus.bi_addr[OFF_W-1:0]};

  // One tag comparator serves both the access lookup and the back-invalidation probe.
  assign lk_blk = (state_q == S_LOOKUP) ? blk_q : bus.bi_addr[31:OFF_W];
  assign lk_idx = lk_blk[IDX_W-1:0];
  assign lk_tag = lk_blk[BLK_W-1:IDX_W];

  always_comb begin
    lk_hit  = 1'b0;
    inv_any = 1'b0;
    hit_way = '0;
    inv_way = '0;
    old_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[lk_idx][w] && (tag_q[lk_idx][w] == lk_tag)) begin
        lk_hit  = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[lk_idx][w]) begin
        inv_any = 1'b1;
        inv_way = WAY_W'(w);
      end
      if (rank_q[lk_idx][w] == WAY_W'(WAYS - 1)) old_way = WAY_W'(w);
    end
    tgt_way  = lk_hit ? hit_way : (inv_any ? inv_way : old_way);
    tgt_rank = rank_q[lk_idx][tgt_way];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_bi)    state_d = S_BINV;
        else if (accept) state_d = S_LOOKUP;
      end
      S_LOOKUP: state_d = S_UPDATE;
      S_UPDATE: state_d = S_IDLE;
      S_BINV:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      live_q        <= 1'b0;
      blk_q         <= '0;
      write_q       <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_hit_q    <= 1'b0;
      evict_valid_q <= 1'b0;
      evict_dirty_q <= 1'b0;
      evict_addr_q  <= '0;
      bi_done_q     <= 1'b0;
      bi_found_q    <= 1'b0;
      hit_count     <= '0;
      miss_count    <= '0;
      wb_count      <= '0;
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
          rank_q[s][w]  <= WAY_W'(w);
        end
      end
    end else begin
      live_q        <= 1'b1;
      resp_valid_q  <= 1'b0;
      evict_valid_q <= 1'b0;
      bi_done_q     <= 1'b0;
      bi_found_q    <= 1'b0;

      if (accept) begin
        blk_q   <= bus.req_addr[31:OFF_W];
        write_q <= bus.req_write;
      end

      // An invalidated line sinks to the oldest rank so the permutation stays intact.
      if (start_bi) begin
        bi_done_q  <= 1'b1;
        bi_found_q <= lk_hit;
        if (lk_hit) begin
          valid_q[lk_idx][hit_way] <= 1'b0;
          dirty_q[lk_idx][hit_way] <= 1'b0;
          for (int w = 0; w < WAYS; w++) begin
            if (WAY_W'(w) == hit_way)
              rank_q[lk_idx][w] <= WAY_W'(WAYS - 1);
            else if (rank_q[lk_idx][w] > tgt_rank)
              rank_q[lk_idx][w] <= rank_q[lk_idx][w] - 1'b1;
          end
        end
      end

      if (state_q == S_LOOKUP) begin
        resp_valid_q <= 1'b1;
        resp_hit_q   <= lk_hit;
        if (lk_hit) begin
          hit_count <= sat_inc(hit_count);
          if (write_q) dirty_q[lk_idx][tgt_way] <= 1'b1;
        end else begin
          miss_count               <= sat_inc(miss_count);
          valid_q[lk_idx][tgt_way] <= 1'b1;
          dirty_q[lk_idx][tgt_way] <= write_q;
          tag_q[lk_idx][tgt_way]   <= lk_tag;
          if (valid_q[lk_idx][tgt_way]) begin
            evict_valid_q <= 1'b1;
            evict_dirty_q <= dirty_q[lk_idx][tgt_way];
            evict_addr_q  <= {tag_q[lk_idx][tgt_way], lk_idx, {OFF_W{1'b0}}};
            if (dirty_q[lk_idx][tgt_way]) wb_count <= sat_inc(wb_count);
          end
        end
        if (!lk_hit || (POLICY == 0)) begin
          for (int w = 0; w < WAYS; w++) begin
            if (WAY_W'(w) == tgt_way)
              rank_q[lk_idx][w] <= '0;
            else if (rank_q[lk_idx][w] < tgt_rank)
              rank_q[lk_idx][w] <= rank_q[lk_idx][w] + 1'b1;
          end
        end
      end
    end
  end

  assign bus.req_ready   = req_ready;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_hit    = resp_hit_q;
  assign bus.evict_valid = evict_valid_q;
  assign bus.evict_addr  = evict_addr_q;
  assign bus.evict_dirty = evict_dirty_q;
  assign bus.bi_done     = bi_done_q;
  assign bus.bi_found    = bi_found_q;
endmodule

// File: tb/tb_l1_cache_param.sv
// tb/tb_l1_cache_param.sv - LRU, FIFO and 2-bit-counter instances driven in lockstep against a recency-list model
module tb_l1_cache_param;
  logic        clk, rst_n;
  logic        req_valid, req_write, bi_valid;
  logic [31:0] req_addr, bi_addr;

  l1_cache_param_if bus[3] ();

  logic [19:0] hc0, mc0, wc0, hc1, mc1, wc1;
  logic [1:0]  hc2, mc2, wc2;

  l1_cache_param #(.POLICY(0)) dut_lru (.clk(clk), .rst_n(rst_n), .bus(bus[0]),
    .hit_count(hc0), .miss_count(mc0), .wb_count(wc0));
  l1_cache_param #(.POLICY(1)) dut_fifo (.clk(clk), .rst_n(rst_n), .bus(bus[1]),
    .hit_count(hc1), .miss_count(mc1), .wb_count(wc1));
  l1_cache_param #(.POLICY(0), .CNT_W(2)) dut_sat (.clk(clk), .rst_n(rst_n), .bus(bus[2]),
    .hit_count(hc2), .miss_count(mc2), .wb_count(wc2));

  logic        o_ready [3], o_rv [3], o_rh [3], o_ev [3], o_ed [3], o_bd [3], o_bf [3];
  logic [31:0] o_ea [3], o_hc [3], o_mc [3], o_wc [3];

  for (genvar g = 0; g < 3; g++) begin : g_tie
    assign bus[g].req_valid = req_valid;
    assign bus[g].req_addr  = req_addr;
    assign bus[g].req_write = req_write;
    assign bus[g].bi_valid  = bi_valid;
    assign bus[g].bi_addr   = bi_addr;
    assign o_ready[g] = bus[g].req_ready;
    assign o_rv[g]    = bus[g].resp_valid;
    assign o_rh[g]    = bus[g].resp_hit;
    assign o_ev[g]    = bus[g].evict_valid;
    assign o_ea[g]    = bus[g].evict_addr;
    assign o_ed[g]    = bus[g].evict_dirty;
    assign o_bd[g]    = bus[g].bi_done;
    assign o_bf[g]    = bus[g].bi_found;
  end

  assign o_hc[0] = {12'b0, hc0};
  assign o_mc[0] = {12'b0, mc0};
  assign o_wc[0] = {12'b0, wc0};
  assign o_hc[1] = {12'b0, hc1};
  assign o_mc[1] = {12'b0, mc1};
  assign o_wc[1] = {12'b0, wc1};
  assign o_hc[2] = {30'b0, hc2};
  assign o_mc[2] = {30'b0, mc2};
  assign o_wc[2] = {30'b0, wc2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Each set is a list of resident lines, newest/most recent at the front.
  typedef struct packed {
    logic [19:0] tag;
    logic        dirty;
  } line_t;
  line_t       mq [3][256][$];
  int unsigned m_hit [3], m_miss [3], m_wb [3];
  logic        e_hit [3], e_ev [3], e_ed [3], e_bf [3];
  logic [31:0] e_ea [3], ob_ea [3];
  logic        ob_rh [3], ob_bf [3];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic string nm(input string s, input int d);
    return $sformatf("%s_%0d", s, d);
  endfunction

  function automatic int unsigned sat(input int d, input int unsigned v);
    int unsigned cap;
    cap = (d == 2) ? 32'd3 : 32'h000F_FFFF;
    return (v == cap) ? v : v + 1;
  endfunction

  task automatic m_clear();
    for (int d = 0; d < 3; d++) begin
      for (int s = 0; s < 256; s++) mq[d][s].delete();
      m_hit[d] = 0;
      m_miss[d] = 0;
      m_wb[d] = 0;
    end
  endtask

  task automatic m_access(input int d, input logic [31:0] a, input logic w);
    logic [7:0]  s;
    logic [19:0] t;
    int          f;
    line_t       ln;
    s = a[11:4];
    t = a[31:12];
    f = -1;
    for (int i = 0; i < mq[d][s].size(); i++) if (mq[d][s][i].tag == t) f = i;
    e_ev[d] = 1'b0;
    e_ed[d] = 1'b0;
    e_ea[d] = '0;
    if (f >= 0) begin
      e_hit[d] = 1'b1;
      m_hit[d] = sat(d, m_hit[d]);
      ln = mq[d][s][f];
      ln.dirty = ln.dirty | w;
      if (d != 1) begin
        mq[d][s].delete(f);
        mq[d][s].push_front(ln);
      end else begin
        mq[d][s][f] = ln;
      end
    end else begin
      e_hit[d] = 1'b0;
      m_miss[d] = sat(d, m_miss[d]);
      if (mq[d][s].size() == 4) begin
        ln = mq[d][s].pop_back();
        e_ev[d] = 1'b1;
        e_ed[d] = ln.dirty;
        e_ea[d] = {ln.tag, s, 4'h0};
        if (ln.dirty) m_wb[d] = sat(d, m_wb[d]);
      end
      ln.tag = t;
      ln.dirty = w;
      mq[d][s].push_front(ln);
    end
  endtask

  task automatic m_binv(input int d, input logic [31:0] a);
    logic [7:0] s;
    int         f;
    s = a[11:4];
    f = -1;
    for (int i = 0; i < mq[d][s].size(); i++) if (mq[d][s][i].tag == a[31:12]) f = i;
    e_bf[d] = (f >= 0);
    if (f >= 0) mq[d][s].delete(f);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!o_ready[0] && n < 16) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", o_ready[0], 1);
  endtask

  task automatic check_counts(input string tag);
    for (int d = 0; d < 3; d++) begin
      check(nm({tag, "_hits"}, d), o_hc[d], m_hit[d]);
      check(nm({tag, "_misses"}, d), o_mc[d], m_miss[d]);
      check(nm({tag, "_wbs"}, d), o_wc[d], m_wb[d]);
    end
  endtask

  task automatic access(input logic [31:0] a, input logic w);
    wait_ready();
    req_valid = 1'b1;
    req_addr  = a;
    req_write = w;
    @(posedge clk);
    for (int d = 0; d < 3; d++) m_access(d, a, w);
    @(negedge clk);
    req_valid = 1'b0;
    for (int d = 0; d < 3; d++) check(nm("lookup_quiet", d), o_rv[d], 0);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check(nm("resp_valid", d), o_rv[d], 1);
      check(nm("resp_hit", d), o_rh[d], e_hit[d]);
      check(nm("evict_valid", d), o_ev[d], e_ev[d]);
      if (e_ev[d]) begin
        check(nm("evict_addr", d), o_ea[d], e_ea[d]);
        check(nm("evict_dirty", d), o_ed[d], e_ed[d]);
      end
      ob_ea[d] = o_ea[d];
      ob_rh[d] = o_rh[d];
    end
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check(nm("resp_pulse", d), o_rv[d], 0);
      check(nm("evict_pulse", d), o_ev[d], 0);
      check(nm("ready_n3", d), o_ready[d], 1);
    end
    check_counts("acc");
  endtask

  task automatic binv(input logic [31:0] a, input logic co, input logic [31:0] ca);
    bi_valid = 1'b1;
    bi_addr  = a;
    if (co) begin
      req_valid = 1'b1;
      req_addr  = ca;
      req_write = 1'b0;
    end
    #1;
    for (int d = 0; d < 3; d++) check(nm("bi_blocks_ready", d), o_ready[d], 0);
    @(posedge clk);
    for (int d = 0; d < 3; d++) m_binv(d, a);
    @(negedge clk);
    bi_valid = 1'b0;
    for (int d = 0; d < 3; d++) begin
      check(nm("bi_done", d), o_bd[d], 1);
      check(nm("bi_found", d), o_bf[d], e_bf[d]);
      check(nm("bi_no_resp", d), o_rv[d], 0);
      ob_bf[d] = o_bf[d];
    end
    @(negedge clk);
    for (int d = 0; d < 3; d++) check(nm("bi_pulse", d), o_bd[d], 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = 1'b0;
    bi_valid = 1'b0;
    m_clear();
    @(negedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check(nm("rst_ready", d), o_ready[d], 0);
      check(nm("rst_resp", d), o_rv[d], 0);
      check(nm("rst_evict", d), o_ev[d], 0);
      check(nm("rst_bi_done", d), o_bd[d], 0);
    end
    check_counts("rst");
    rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 3; d++) check(nm("ready_after_rst", d), o_ready[d], 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a, ca;
    int          r;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr = '0;
    bi_valid = 1'b0;
    bi_addr = '0;

    do_reset();
    access(32'h0000_1000, 1'b0);
    check("first_miss_evict", {31'b0, ob_rh[0]}, 0);
    check("first_miss_count", o_mc[0], 1);
    access(32'h0000_1000, 1'b0);
    check("second_hit", {31'b0, ob_rh[0]}, 1);
    check("second_hit_count", o_hc[0], 1);

    do_reset();
    access(32'h0000_0000, 1'b0);
    access(32'h0000_2000, 1'b0);
    access(32'h0000_4000, 1'b0);
    access(32'h0000_6000, 1'b0);
    access(32'h0000_0000, 1'b0);
    access(32'h0000_8000, 1'b0);
    check("lru_victim", ob_ea[0], 32'h0000_2000);
    check("fifo_victim", ob_ea[1], 32'h0000_0000);

    access(32'h0000_0010, 1'b1);
    access(32'h0000_2010, 1'b0);
    access(32'h0000_4010, 1'b0);
    access(32'h0000_6010, 1'b0);
    access(32'h0000_8010, 1'b0);
    check("dirty_victim_lru", ob_ea[0], 32'h0000_0010);
    check("dirty_victim_fifo", ob_ea[1], 32'h0000_0010);
    check("wb_count_lru", o_wc[0], 1);

    wait_ready();
    req_valid = 1'b1;
    req_addr  = 32'h0000_1000;
    req_write = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = 1'b0;
    m_clear();
    @(negedge clk);
    for (int d = 0; d < 3; d++) check(nm("abort_no_resp", d), o_rv[d], 0);
    check_counts("abort");
    @(negedge clk);
    for (int d = 0; d < 3; d++) check(nm("abort_no_resp2", d), o_rv[d], 0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 3; d++) check(nm("abort_ready", d), o_ready[d], 1);

    access(32'h0000_2000, 1'b0);
    binv(32'h0000_2000, 1'b1, 32'h0000_2000);
    check("bi_found_present", {31'b0, ob_bf[0]}, 1);
    access(32'h0000_2000, 1'b0);
    check("reload_after_bi_misses", {31'b0, ob_rh[0]}, 0);
    binv(32'h0000_6000, 1'b0, 32'h0);
    check("bi_found_absent", {31'b0, ob_bf[0]}, 0);

    for (int i = 0; i < 300; i++) begin
      r  = $urandom_range(0, 9);
      a  = ($urandom_range(0, 5) << 12) | ($urandom_range(0, 2) << 4) | $urandom_range(0, 15);
      ca = ($urandom_range(0, 5) << 12) | ($urandom_range(0, 2) << 4) | $urandom_range(0, 15);
      if (r < 2) begin
        binv(a, (r == 0), ca);
        if (r == 0) access(ca, 1'b0);
      end else begin
        access(a, 1'($urandom_range(0, 1)));
      end
    end
    check("sat_miss_count", o_mc[2], 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
